pool_window_2x2: RTL
====================

POOL_WINDOW_2X2 -- requirements
Module: pool_window_2x2

Interface
REQ-001 Parameter IMG_W, default 28, feature-map width in pixels; even, >= 2.
REQ-002 Parameter IMG_H, default 28, feature-map height in pixels; even, >= 2.
REQ-003 Parameter DATA_W, default 16, pixel width in bits (fp16 pattern, carried opaquely).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_data holds a valid pixel.
REQ-007 in_ready  output  1  block accepts the pixel this cycle.
REQ-008 in_data  input  DATA_W  pixel, raster order (row-major, top-left first).
REQ-009 out_valid  output  1  window outputs are valid.
REQ-010 out_ready  input  1  downstream 2x2 averager accepts the window.
REQ-011 out_a  output  DATA_W  window top-left pixel.
REQ-012 out_b  output  DATA_W  window top-right pixel.
REQ-013 out_c  output  DATA_W  window bottom-left pixel.
REQ-014 out_d  output  DATA_W  window bottom-right pixel.
REQ-015 out_last  output  1  qualifies the final window of a frame; valid only with out_valid.

Function
REQ-016 Pixel transfer occurs on a clock edge with in_valid && in_ready; window transfer occurs with out_valid && out_ready.
REQ-017 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on pixel transfer; col wraps to 0 and row increments at IMG_W-1; both wrap to 0 after pixel (IMG_W-1, IMG_H-1).
REQ-018 Pixels with even row are written to line-buffer entry col; no output.
REQ-019 A pixel with odd row and even col is held in a bottom-left register.
REQ-020 A pixel with odd row and odd col completes a window: a=buf[col-1], b=buf[col], c=bottom-left register, d=in_data.
REQ-021 Window registers and out_valid load on the edge that accepts the completing pixel; latency 1 cycle from the bottom-right pixel transfer to out_valid.
REQ-022 out_last = 1 for the window completed by pixel (IMG_W-1, IMG_H-1), else 0.
REQ-023 Windows stride 2, non-overlapping; exactly (IMG_W/2)*(IMG_H/2) windows per frame, in raster order.
REQ-024 in_ready = !out_valid || out_ready (single-entry output register; a pending window stalls input).
REQ-025 out_valid clears after window transfer unless a new window loads on the same edge; simultaneous transfer and load yields the new window with out_valid kept at 1.
REQ-026 out_a..out_d and out_last hold stable while out_valid && !out_ready.
REQ-027 Consecutive frames stream without gaps; frame N+1 pixel 0 may transfer on the cycle after frame N's last pixel.
REQ-028 Line-buffer write on an even row never overwrites an entry before the odd-row read for that column pair (guaranteed by raster ordering; no extra interlock).

Reset
REQ-029 While rst_n = 0 on a clock edge: col = 0, row = 0, out_valid = 0, out_last = 0, out_a..out_d = 0; in_ready = 1 the cycle after reset deasserts.
REQ-030 Reset mid-frame discards the partial frame and any pending window; the next accepted pixel is treated as (0,0).
REQ-031 Line-buffer and bottom-left register contents are not reset (don't-care).

Structure
REQ-032 Shared package pool_pkg holds DATA_W default, fp16 pixel typedef, default IMG_W/IMG_H constants.
REQ-033 Line buffer is sub-module pool_line_buf: IMG_W x DATA_W, one write port, two combinational read ports (col-1, col), inferrable as distributed RAM.
REQ-034 Elaboration-time check rejects odd or < 2 IMG_W/IMG_H.

Verification
REQ-035 IMG_W=IMG_H=4, in_data = 0..15, in_valid=1, out_ready=1 -> windows (0,1,4,5),(2,3,6,7),(8,9,12,13),(10,11,14,15); out_last only on 4th; each out_valid 1 cycle after pixels 5,7,13,15.
REQ-036 Same frame, out_ready=0 for 5 cycles when window (0,1,4,5) appears -> outputs held stable, in_ready=0 while stalled, no pixel lost, same 4 windows.
REQ-037 Two back-to-back 4x4 frames (0..15, 16..31) -> 8 windows, second frame first window (16,17,20,21), out_last on windows 4 and 8.
REQ-038 Reset pulsed after pixel 9 of a 4x4 frame, then full frame 100..115 -> pending window dropped, windows (100,101,104,105)...(110,111,114,115) only.
REQ-039 Default 28x28, random in_valid and out_ready (50%) with fp16 patterns -> exactly 196 windows matching a reference model, one out_last.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared pixel type and default geometry for the 2x2 pooling window front end.
package pool_pkg;

    localparam int POOL_DATA_W = 16;
    localparam int POOL_IMG_W  = 28;
    localparam int POOL_IMG_H  = 28;

    // fp16 bit pattern; the window extractor never interprets it.
    typedef logic [POOL_DATA_W-1:0] fp16_t;

    function automatic bit pool_dim_ok(input int dim);
        return (dim >= 2) && ((dim % 2) == 0);
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports so the
// left and right pixels of an upper window row can be fetched together.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int IMG_W  = POOL_IMG_W,
    parameter int DATA_W = POOL_DATA_W,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o
);

    // Contents are deliberately not reset so the array maps onto distributed RAM.
    logic [DATA_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/pool_window_2x2.sv
// 2x2 stride-2 window extractor: even rows go to a line buffer, odd rows pair
// with it to emit one (a b / c d) window per bottom-right pixel.
module pool_window_2x2
    import pool_pkg::*;
#(
    parameter int IMG_W  = POOL_IMG_W,
    parameter int IMG_H  = POOL_IMG_H,
    parameter int DATA_W = POOL_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic              out_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    if (!pool_dim_ok(IMG_W) || !pool_dim_ok(IMG_H)) begin : g_bad_dims
        $error("pool_window_2x2: IMG_W and IMG_H must be even and >= 2");
    end

    // Valid/ready on both sides: a beat moves on a rising edge where valid and
    // ready are both high; valid never depends on ready, and a presented window
    // (data and last) stays frozen while out_valid is high and out_ready is low.
    logic pix_xfer;
    logic win_xfer;
    logic win_load;
    logic bl_load;
    logic buf_wr;
    logic frame_end;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_left;

    logic [DATA_W-1:0] rd_left;
    logic [DATA_W-1:0] rd_right;
    logic [DATA_W-1:0] bl_q;

    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] d_q, d_d;

    assign in_ready  = !valid_q || out_ready;
    assign pix_xfer  = in_valid && in_ready;
    assign win_xfer  = valid_q && out_ready;
    assign frame_end = (col_q == COL_MAX) && (row_q == ROW_MAX);

    // Row parity selects the role of the pixel, column parity its side of the pair.
    assign buf_wr   = pix_xfer && !row_q[0];
    assign bl_load  = pix_xfer && row_q[0] && !col_q[0];
    assign win_load = pix_xfer && row_q[0] && col_q[0];
    assign col_left = col_q - COL_W'(1);

    pool_line_buf #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_line_buf (
        .clk         (clk),
        .wr_en_i     (buf_wr),
        .wr_addr_i   (col_q),
        .wr_data_i   (in_data),
        .rd_addr_a_i (col_left),
        .rd_data_a_o (rd_left),
        .rd_addr_b_i (col_q),
        .rd_data_b_o (rd_right)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_xfer) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bl_load) begin
            bl_q <= in_data;
        end
    end

    // A load wins over a drain on the same edge, so back-to-back windows keep valid high.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        if (win_load) begin
            valid_d = 1'b1;
            last_d  = frame_end;
            a_d     = rd_left;
            b_d     = rd_right;
            c_d     = bl_q;
            d_d     = in_data;
        end else if (win_xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_c     = c_q;
    assign out_d     = d_q;

endmodule
